// File: rtl/eth_udp_rx.sv
// Ethernet/IPv4/UDP receive filter: forwards dst IP, dst port and UDP payload of accepted frames.
// Optional macro IPV4_CSUM_CHECK_EN adds an IPv4 header checksum check at byte 34.
module eth_udp_rx #(
  parameter logic [47:0] LOCAL_MAC = 48'h000A35010203,
  parameter logic [15:0] PORT_MIN  = 16'd1024,
  parameter logic [15:0] PORT_MAX  = 16'd65535
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] mac_din,
  input  logic       mac_din_en,
  output logic [7:0] udp_dout,
  output logic       udp_dout_en,
  output logic       frame_drop
);
  // Stream semantics: a byte moves whenever its enable is high; there is no backpressure.
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_PREFIX, S_PAYLOAD, S_DISCARD} state_t;

  state_t      state_q, state_d;
  logic [10:0] cnt_q, cnt_d;
  logic        prev_en_q, prev_en_d;
  logic        mcast_q, mcast_d, local_q, local_d;
  logic [31:0] ip_q, ip_d;
  logic [15:0] port_q, port_d, left_q, left_d;
  logic [7:0]  len_hi_q, len_hi_d;
  logic [7:0]  udp_dout_q, udp_dout_d;
  logic        udp_dout_en_q, udp_dout_en_d, frame_drop_q, frame_drop_d;

  logic        byte_vld, hdr_fail, port_bad, len_bad;
  logic [7:0]  lmac_byte;
  logic [15:0] port_now, len_now;
  logic [16:0] port_lo_diff, port_hi_diff;
`ifdef IPV4_CSUM_CHECK_EN
  logic [15:0] csum_q, csum_d;
  logic [7:0]  csum_hi_q, csum_hi_d;
  logic [16:0] csum_sum;
`endif

  always_comb begin
    case (cnt_q[2:0])
      3'd0:    lmac_byte = LOCAL_MAC[47:40];
      3'd1:    lmac_byte = LOCAL_MAC[39:32];
      3'd2:    lmac_byte = LOCAL_MAC[31:24];
      3'd3:    lmac_byte = LOCAL_MAC[23:16];
      3'd4:    lmac_byte = LOCAL_MAC[15:8];
      default: lmac_byte = LOCAL_MAC[7:0];
    endcase
  end

  // Range checks via subtraction borrow so full-range limits stay plain arithmetic.
  always_comb begin
    port_now     = {port_q[15:8], mac_din};
    len_now      = {len_hi_q, mac_din};
    port_lo_diff = {1'b0, port_now} - {1'b0, PORT_MIN};
    port_hi_diff = {1'b0, PORT_MAX} - {1'b0, port_now};
    port_bad     = port_lo_diff[16] | port_hi_diff[16];
    len_bad      = (len_now <= 16'd8);
    byte_vld     = mac_din_en && (cnt_q != 11'h7FF);
    case (cnt_q)
      11'd5:   hdr_fail = !(mcast_q || (local_q && (mac_din == lmac_byte)));
      11'd12:  hdr_fail = (mac_din != 8'h08);
      11'd13:  hdr_fail = (mac_din != 8'h00);
      11'd14:  hdr_fail = (mac_din != 8'h45);
      11'd20:  hdr_fail = (mac_din[5:0] != 6'd0);
      11'd21:  hdr_fail = (mac_din != 8'h00);
      11'd23:  hdr_fail = (mac_din != 8'd17);
`ifdef IPV4_CSUM_CHECK_EN
      11'd34:  hdr_fail = (csum_q != 16'hFFFF);
`endif
      default: hdr_fail = 1'b0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = !mac_din_en ? 11'd0 : (cnt_q == 11'h7FF) ? cnt_q : cnt_q + 11'd1;
    prev_en_d     = mac_din_en;
    mcast_d       = mcast_q;
    local_d       = local_q;
    ip_d          = ip_q;
    port_d        = port_q;
    len_hi_d      = len_hi_q;
    left_d        = left_q;
    udp_dout_d    = 8'h00;
    udp_dout_en_d = 1'b0;
    frame_drop_d  = 1'b0;
`ifdef IPV4_CSUM_CHECK_EN
    csum_d        = csum_q;
    csum_hi_d     = csum_hi_q;
    csum_sum      = {1'b0, csum_q} + {1'b0, csum_hi_q, mac_din};
    if (byte_vld) begin
      if (cnt_q == 11'd0) csum_d = 16'h0000;
      else if (cnt_q >= 11'd14 && cnt_q <= 11'd33) begin
        if (!cnt_q[0]) csum_hi_d = mac_din;
        else           csum_d    = csum_sum[15:0] + {15'd0, csum_sum[16]};
      end
    end
`endif

    if (byte_vld) begin
      if (cnt_q == 11'd0) begin
        mcast_d = mac_din[0];
        local_d = (mac_din == lmac_byte);
      end else if (cnt_q <= 11'd4) begin
        local_d = local_q && (mac_din == lmac_byte);
      end
      if (cnt_q >= 11'd30 && cnt_q <= 11'd33) ip_d = {ip_q[23:0], mac_din};
      if (cnt_q == 11'd36) port_d[15:8] = mac_din;
      if (cnt_q == 11'd37) port_d[7:0]  = mac_din;
      if (cnt_q == 11'd38) len_hi_d     = mac_din;
    end

    case (state_q)
      S_IDLE: begin
        // Enable already high here means we came out of reset mid-frame.
        if (mac_din_en) state_d = prev_en_q ? S_DISCARD : S_HDR;
      end
      S_HDR: begin
        if (!mac_din_en) begin
          frame_drop_d = 1'b1;
          state_d      = S_IDLE;
        end else if (byte_vld) begin
          if (hdr_fail) begin
            frame_drop_d = 1'b1;
            state_d      = S_DISCARD;
          end else if (cnt_q == 11'd36) begin
            udp_dout_d    = ip_q[31:24];
            udp_dout_en_d = 1'b1;
            state_d       = S_PREFIX;
          end
        end
      end
      S_PREFIX: begin
        if (!mac_din_en) begin
          frame_drop_d = 1'b1;
          state_d      = S_IDLE;
        end else if (byte_vld) begin
          udp_dout_en_d = 1'b1;
          case (cnt_q)
            11'd37:  udp_dout_d = ip_q[23:16];
            11'd38:  udp_dout_d = ip_q[15:8];
            11'd39:  udp_dout_d = ip_q[7:0];
            11'd40:  udp_dout_d = port_q[15:8];
            default: udp_dout_d = port_q[7:0];
          endcase
          if (cnt_q == 11'd39) left_d = len_now - 16'd8;
          if (cnt_q == 11'd41) state_d = S_PAYLOAD;
          if ((cnt_q == 11'd37 && port_bad) || (cnt_q == 11'd39 && len_bad)) begin
            udp_dout_d    = 8'h00;
            udp_dout_en_d = 1'b0;
            frame_drop_d  = 1'b1;
            state_d       = S_DISCARD;
          end
        end
      end
      S_PAYLOAD: begin
        if (!mac_din_en) begin
          frame_drop_d = 1'b1;
          state_d      = S_IDLE;
        end else if (byte_vld) begin
          udp_dout_d    = mac_din;
          udp_dout_en_d = 1'b1;
          left_d        = left_q - 16'd1;
          if (left_q == 16'd1) state_d = S_DISCARD;
        end
      end
      default: begin
        if (!mac_din_en) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= 11'd0;
      prev_en_q     <= 1'b1;
      mcast_q       <= 1'b0;
      local_q       <= 1'b0;
      ip_q          <= 32'd0;
      port_q        <= 16'd0;
      len_hi_q      <= 8'd0;
      left_q        <= 16'd0;
      udp_dout_q    <= 8'd0;
      udp_dout_en_q <= 1'b0;
      frame_drop_q  <= 1'b0;
`ifdef IPV4_CSUM_CHECK_EN
      csum_q        <= 16'd0;
      csum_hi_q     <= 8'd0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      prev_en_q     <= prev_en_d;
      mcast_q       <= mcast_d;
      local_q       <= local_d;
      ip_q          <= ip_d;
      port_q        <= port_d;
      len_hi_q      <= len_hi_d;
      left_q        <= left_d;
      udp_dout_q    <= udp_dout_d;
      udp_dout_en_q <= udp_dout_en_d;
      frame_drop_q  <= frame_drop_d;
`ifdef IPV4_CSUM_CHECK_EN
      csum_q        <= csum_d;
      csum_hi_q     <= csum_hi_d;
`endif
    end
  end

  assign udp_dout    = udp_dout_q;
  assign udp_dout_en = udp_dout_en_q;
  assign frame_drop  = frame_drop_q;
endmodule

// File: tb/tb_eth_udp_rx.sv
// Directed bench for eth_udp_rx: builds frames byte by byte and checks the forwarded stream.
module tb_eth_udp_rx;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] mac_din = 8'h00;
  logic       mac_din_en = 1'b0;
  logic [7:0] udp_dout;
  logic       udp_dout_en;
  logic       frame_drop;

  localparam logic [47:0] LMAC = 48'h000A35010203;

  eth_udp_rx dut (
    .clk(clk), .rst(rst), .mac_din(mac_din), .mac_din_en(mac_din_en),
    .udp_dout(udp_dout), .udp_dout_en(udp_dout_en), .frame_drop(frame_drop)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0] frm [0:2047];
  int         frm_len;
  int         in_cyc [0:2047];
  logic [15:0] cur_ulen;
  int         seed_ctr = 0;

  logic [7:0] out_q[$];
  logic [7:0] exp_q[$];
  int drop_cnt, burst_cnt, first_out_cyc, first_end_cyc;
  logic mon_prev_en = 1'b0;

  always @(negedge clk) begin
    if (udp_dout_en) begin
      if (out_q.size() == 0) first_out_cyc = cyc;
      out_q.push_back(udp_dout);
      if (!mon_prev_en) burst_cnt++;
    end else if (mon_prev_en && first_end_cyc < 0) begin
      first_end_cyc = cyc - 1;
    end
    if (frame_drop) drop_cnt++;
    mon_prev_en = udp_dout_en;
  end

  task automatic clear_mon();
    out_q.delete();
    exp_q.delete();
    drop_cnt = 0;
    burst_cnt = 0;
    first_out_cyc = -1;
    first_end_cyc = -1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic build(input logic [47:0] mac, input logic [15:0] etype, input logic [7:0] proto,
                       input logic [15:0] port, input logic [15:0] ulen, input int total,
                       input int csum_err);
    int sum;
    int plen;
    logic [15:0] ck;
    logic [15:0] iplen;
    plen = (ulen > 16'd8) ? int'(ulen) - 8 : 0;
    frm_len = 42 + plen;
    if (total > frm_len) frm_len = total;
    for (int i = 0; i < frm_len; i++) frm[i] = 8'h00;
    for (int i = 0; i < 6; i++) frm[i] = mac[47-8*i -: 8];
    for (int i = 6; i < 12; i++) frm[i] = 8'(i * 17);
    iplen = 16'd20 + ulen;
    frm[12] = etype[15:8]; frm[13] = etype[7:0];
    frm[14] = 8'h45; frm[15] = 8'h00; frm[16] = iplen[15:8]; frm[17] = iplen[7:0];
    frm[18] = 8'h12; frm[19] = 8'h34; frm[20] = 8'h40; frm[21] = 8'h00;
    frm[22] = 8'h40; frm[23] = proto;
    frm[26] = 8'h0A; frm[27] = 8'h00; frm[28] = 8'h00; frm[29] = 8'h01;
    frm[30] = 8'hC0; frm[31] = 8'h12; frm[32] = 8'h08; frm[33] = 8'h08;
    frm[34] = 8'h10; frm[35] = 8'h00;
    frm[36] = port[15:8]; frm[37] = port[7:0]; frm[38] = ulen[15:8]; frm[39] = ulen[7:0];
    for (int k = 0; k < plen; k++) frm[42+k] = 8'(k * 7 + 3 + seed_ctr);
    seed_ctr++;
    sum = 0;
    for (int i = 14; i < 34; i += 2) sum += {frm[i], frm[i+1]};
    while (sum > 32'hFFFF) sum = (sum & 32'hFFFF) + (sum >> 16);
    ck = ~sum[15:0] + 16'(csum_err);
    frm[24] = ck[15:8]; frm[25] = ck[7:0];
    cur_ulen = ulen;
  endtask

  task automatic build_exp(input int n_sent);
    for (int i = 36; i < 42 && i < n_sent; i++) exp_q.push_back((i < 40) ? frm[i-6] : frm[i-4]);
    for (int i = 42; i < n_sent && i < 42 + int'(cur_ulen) - 8; i++) exp_q.push_back(frm[i]);
  endtask

  task automatic send(input int n, input int rst_at);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      mac_din = frm[i];
      mac_din_en = 1'b1;
      rst = (i == rst_at);
      in_cyc[i] = cyc;
    end
    @(negedge clk);
    mac_din_en = 1'b0;
    mac_din = 8'h00;
    rst = 1'b0;
  endtask

  task automatic count_bad(output int bad);
    bad = 0;
    foreach (exp_q[i]) if (i >= out_q.size() || out_q[i] !== exp_q[i]) bad++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    n_checks++;
    if (udp_dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %h want 00", udp_dout); end
    n_checks++;
    if (udp_dout_en !== 1'b0) begin n_fail++; $display("FAIL reset_dout_en: got %b want 0", udp_dout_en); end
    n_checks++;
    if (frame_drop !== 1'b0) begin n_fail++; $display("FAIL reset_drop: got %b want 0", frame_drop); end
    rst = 1'b0;
    idle(3);
  endtask

  task automatic test_unicast();
    logic [7:0] pre [0:5];
    int bad;
    pre[0] = 8'hC0; pre[1] = 8'h12; pre[2] = 8'h08; pre[3] = 8'h08; pre[4] = 8'h19; pre[5] = 8'h18;
    clear_mon();
    build(LMAC, 16'h0800, 8'd17, 16'h1918, 16'd384, 0, 0);
    build_exp(frm_len);
    send(frm_len, -1);
    idle(4);
    n_checks++;
    if (out_q.size() != 382) begin n_fail++; $display("FAIL unicast_len: got %0d want 382", out_q.size()); end
    bad = 0;
    for (int i = 0; i < 6; i++) if (i >= out_q.size() || out_q[i] !== pre[i]) bad++;
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL unicast_prefix: %0d wrong of 6 (first got %h want C0)", bad, (out_q.size() > 0) ? out_q[0] : 8'hxx); end
    count_bad(bad);
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL unicast_data: %0d wrong bytes want 0", bad); end
    n_checks++;
    if (first_out_cyc - in_cyc[36] != 1) begin n_fail++; $display("FAIL unicast_latency: got %0d want 1", first_out_cyc - in_cyc[36]); end
    n_checks++;
    if (drop_cnt != 0) begin n_fail++; $display("FAIL unicast_drop: got %0d want 0", drop_cnt); end
    n_checks++;
    if (burst_cnt != 1) begin n_fail++; $display("FAIL unicast_bursts: got %0d want 1", burst_cnt); end
  endtask

  task automatic test_padding();
    int bad;
    clear_mon();
    build(LMAC, 16'h0800, 8'd17, 16'h1918, 16'd196, 300, 0);
    build_exp(frm_len);
    send(frm_len, -1);
    idle(4);
    n_checks++;
    if (out_q.size() != 194) begin n_fail++; $display("FAIL pad_len: got %0d want 194", out_q.size()); end
    count_bad(bad);
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL pad_data: %0d wrong bytes want 0", bad); end
    n_checks++;
    if (first_end_cyc != in_cyc[229] + 1) begin n_fail++; $display("FAIL pad_end: got %0d want %0d", first_end_cyc, in_cyc[229] + 1); end
    n_checks++;
    if (drop_cnt != 0) begin n_fail++; $display("FAIL pad_drop: got %0d want 0", drop_cnt); end
  endtask

  task automatic test_reject();
    clear_mon();
    build(LMAC, 16'h0806, 8'd17, 16'h1918, 16'd384, 0, 0);
    send(frm_len, -1);
    idle(3);
    n_checks++;
    if (out_q.size() != 0 || drop_cnt != 1) begin n_fail++; $display("FAIL arp: got %0d bytes %0d drops want 0 1", out_q.size(), drop_cnt); end
    clear_mon();
    build(LMAC, 16'h0800, 8'd6, 16'h1918, 16'd384, 0, 0);
    send(frm_len, -1);
    idle(3);
    n_checks++;
    if (out_q.size() != 0 || drop_cnt != 1) begin n_fail++; $display("FAIL tcp: got %0d bytes %0d drops want 0 1", out_q.size(), drop_cnt); end
    clear_mon();
    build(LMAC, 16'h0800, 8'd17, 16'h1918, 16'd384, 30, 0);
    send(30, -1);
    idle(3);
    n_checks++;
    if (out_q.size() != 0 || drop_cnt != 1) begin n_fail++; $display("FAIL short: got %0d bytes %0d drops want 0 1", out_q.size(), drop_cnt); end
  endtask

  task automatic test_mac();
    clear_mon();
    build(48'hFFFFFFFFFFFF, 16'h0800, 8'd17, 16'h1918, 16'd20, 0, 0);
    send(frm_len, -1);
    idle(3);
    n_checks++;
    if (out_q.size() != 18 || drop_cnt != 0) begin n_fail++; $display("FAIL bcast: got %0d bytes %0d drops want 18 0", out_q.size(), drop_cnt); end
    clear_mon();
    build(48'h01005E000001, 16'h0800, 8'd17, 16'h1918, 16'd20, 0, 0);
    send(frm_len, -1);
    idle(3);
    n_checks++;
    if (out_q.size() != 18 || drop_cnt != 0) begin n_fail++; $display("FAIL mcast: got %0d bytes %0d drops want 18 0", out_q.size(), drop_cnt); end
    clear_mon();
    build(48'h000A35010204, 16'h0800, 8'd17, 16'h1918, 16'd20, 0, 0);
    send(frm_len, -1);
    idle(3);
    n_checks++;
    if (out_q.size() != 0 || drop_cnt != 1) begin n_fail++; $display("FAIL other_mac: got %0d bytes %0d drops want 0 1", out_q.size(), drop_cnt); end
  endtask

  task automatic test_port_len();
    clear_mon();
    build(LMAC, 16'h0800, 8'd17, 16'h0050, 16'd20, 0, 0);
    send(frm_len, -1);
    idle(3);
    n_checks++;
    if (out_q.size() != 1 || drop_cnt != 1) begin n_fail++; $display("FAIL port_low: got %0d bytes %0d drops want 1 1", out_q.size(), drop_cnt); end
    n_checks++;
    if (out_q.size() < 1 || out_q[0] !== 8'hC0) begin n_fail++; $display("FAIL port_low_ip0: got %h want C0", (out_q.size() > 0) ? out_q[0] : 8'hxx); end
    clear_mon();
    build(LMAC, 16'h0800, 8'd17, 16'd1023, 16'd20, 0, 0);
    send(frm_len, -1);
    idle(3);
    n_checks++;
    if (out_q.size() != 1 || drop_cnt != 1) begin n_fail++; $display("FAIL port_1023: got %0d bytes %0d drops want 1 1", out_q.size(), drop_cnt); end
    clear_mon();
    build(LMAC, 16'h0800, 8'd17, 16'd1024, 16'd20, 0, 0);
    send(frm_len, -1);
    idle(3);
    n_checks++;
    if (out_q.size() != 18 || drop_cnt != 0) begin n_fail++; $display("FAIL port_1024: got %0d bytes %0d drops want 18 0", out_q.size(), drop_cnt); end
    clear_mon();
    build(LMAC, 16'h0800, 8'd17, 16'hFFFF, 16'd9, 0, 0);
    send(frm_len, -1);
    idle(3);
    n_checks++;
    if (out_q.size() != 7 || drop_cnt != 0) begin n_fail++; $display("FAIL len9_portmax: got %0d bytes %0d drops want 7 0", out_q.size(), drop_cnt); end
    clear_mon();
    build(LMAC, 16'h0800, 8'd17, 16'h1918, 16'd8, 0, 0);
    send(frm_len, -1);
    idle(3);
    n_checks++;
    if (out_q.size() != 3 || drop_cnt != 1) begin n_fail++; $display("FAIL len8: got %0d bytes %0d drops want 3 1", out_q.size(), drop_cnt); end
  endtask

  task automatic test_back_to_back();
    int bad;
    int last_in;
    clear_mon();
    build(LMAC, 16'h0800, 8'd17, 16'h1918, 16'd384, 0, 0);
    build_exp(101);
    send(101, -1);
    last_in = in_cyc[100];
    build(LMAC, 16'h0800, 8'd17, 16'h1918, 16'd384, 0, 0);
    build_exp(frm_len);
    send(frm_len, -1);
    idle(4);
    n_checks++;
    if (first_end_cyc != last_in + 1) begin n_fail++; $display("FAIL trunc_end: got %0d want %0d", first_end_cyc, last_in + 1); end
    n_checks++;
    if (out_q.size() != 65 + 382) begin n_fail++; $display("FAIL b2b_len: got %0d want 447", out_q.size()); end
    count_bad(bad);
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL b2b_data: %0d wrong bytes want 0", bad); end
    n_checks++;
    if (drop_cnt != 1 || burst_cnt != 2) begin n_fail++; $display("FAIL b2b_drop: got %0d drops %0d bursts want 1 2", drop_cnt, burst_cnt); end
  endtask

  task automatic test_reset_mid();
    int bad;
    clear_mon();
    build(LMAC, 16'h0800, 8'd17, 16'h1918, 16'd384, 0, 0);
    build_exp(60);
    send(frm_len, 60);
    idle(2);
    n_checks++;
    if (out_q.size() != 24) begin n_fail++; $display("FAIL rst_mid_len: got %0d want 24", out_q.size()); end
    build(LMAC, 16'h0800, 8'd17, 16'h1918, 16'd384, 0, 0);
    build_exp(frm_len);
    send(frm_len, -1);
    idle(4);
    n_checks++;
    if (out_q.size() != 24 + 382) begin n_fail++; $display("FAIL rst_next_len: got %0d want 406", out_q.size()); end
    count_bad(bad);
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL rst_next_data: %0d wrong bytes want 0", bad); end
  endtask

  task automatic test_csum();
    int bad;
    clear_mon();
    build(LMAC, 16'h0800, 8'd17, 16'h1918, 16'd384, 0, 1);
    send(frm_len, -1);
    idle(3);
`ifdef IPV4_CSUM_CHECK_EN
    n_checks++;
    if (out_q.size() != 0 || drop_cnt != 1) begin n_fail++; $display("FAIL csum_bad: got %0d bytes %0d drops want 0 1", out_q.size(), drop_cnt); end
`else
    n_checks++;
    if (out_q.size() != 382 || drop_cnt != 0) begin n_fail++; $display("FAIL csum_ignored: got %0d bytes %0d drops want 382 0", out_q.size(), drop_cnt); end
`endif
    clear_mon();
    build(LMAC, 16'h0800, 8'd17, 16'h1918, 16'd384, 0, 0);
    build_exp(frm_len);
    send(frm_len, -1);
    idle(4);
    count_bad(bad);
    n_checks++;
    if (out_q.size() != 382 || bad != 0 || drop_cnt != 0) begin n_fail++; $display("FAIL csum_good: got %0d bytes %0d wrong %0d drops want 382 0 0", out_q.size(), bad, drop_cnt); end
  endtask

  initial begin
    test_reset();
    test_unicast();
    test_padding();
    test_reject();
    test_mac();
    test_port_len();
    test_back_to_back();
    test_reset_mid();
    test_csum();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/eth_udp_rx.md
Name: eth_udp_rx

Overview:
- Receive-side parser directly upstream of the UDP-to-TS splitter.
- Consumes a byte-wide Ethernet frame from the MAC (preamble/SFD and FCS already stripped) and filters for IPv4/UDP.
- Emits the stream format the splitter expects on one contiguous enable burst: 4 bytes destination IP (MSB first), 2 bytes destination UDP port (MSB first), then exactly the UDP payload bytes (TS packets).
- All other frames are silently discarded and counted via a drop pulse.

Parameters:
- LOCAL_MAC, 48'h000A35010203, unicast destination MAC accepted in addition to broadcast and multicast (first-byte bit0 = 1).
- PORT_MIN, 16'd1024, lowest accepted UDP destination port (inclusive).
- PORT_MAX, 16'd65535, highest accepted UDP destination port (inclusive).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- mac_din  in  8  frame byte; byte 0 = first destination MAC byte.
- mac_din_en  in  1  high for every valid byte of one frame, contiguous; low at least 1 cycle between frames.
- udp_dout  out  8  output byte (IP/port prefix, then payload).
- udp_dout_en  out  1  high for each valid udp_dout byte; one contiguous burst per accepted frame.
- frame_drop  out  1  one-cycle pulse per rejected or truncated frame.

Behaviour:
- Reset: udp_dout=0, udp_dout_en=0, frame_drop=0, byte counter=0, state=IDLE.
- Byte counter: 11 bits, incremented per mac_din_en cycle, cleared when mac_din_en is low. Saturates at 2047; bytes beyond that are ignored.
- Checks, evaluated at the byte index given; any failure means REJECT:
  - Destination MAC (0-5): LOCAL_MAC, broadcast, or multicast.
  - Ethertype (12-13) = 0x0800.
  - Version/IHL (14) = 0x45; options not supported.
  - Flags/fragment (20-21): MF=0 and offset=0.
  - Protocol (23) = 17.
  - UDP destination port (36-37) within [PORT_MIN, PORT_MAX].
  - UDP length (38-39) > 8.
- Capture: destination IP from bytes 30-33, port from 36-37, UDP length from 38-39. payload_left = UDP length − 8.
- States:
  - IDLE → HDR on first mac_din_en.
  - HDR → PREFIX at byte 36 if all checks so far pass; otherwise → DISCARD.
  - PREFIX emits IP0 at byte 36, IP1 at 37, IP2 at 38, IP3 at 39, PORT_HI at 40, PORT_LO at 41. The port is final by byte 38. A port or length failure detected at byte 37/39 aborts to DISCARD, dropping udp_dout_en immediately and pulsing frame_drop.
  - PREFIX → PAYLOAD at byte 42. Each payload byte is forwarded and payload_left decrements. At payload_left = 0 → DISCARD; trailing Ethernet padding is never forwarded.
  - DISCARD → IDLE when mac_din_en is low.
- Latency: registered output, udp_dout/udp_dout_en lag the corresponding input byte by exactly 1 cycle. Burst length = 6 + UDP length − 8.
- Truncation: if mac_din_en falls before payload_left reaches 0 (including mid-prefix), udp_dout_en drops on the next cycle, frame_drop pulses once, and the state returns to IDLE.
- Simultaneous abort and end of frame produce one frame_drop pulse only.
- Reset asserted mid-frame: outputs are cleared next cycle. If mac_din_en is still high after reset is released, the block enters DISCARD and ignores the remainder of that frame; no partial output.
- Frames shorter than 42 bytes: rejected, frame_drop pulses once at the enable falling edge.

Optional Feature:
- Macro IPV4_CSUM_CHECK_EN.
- Defined: a ones'-complement sum over bytes 14-33 is accumulated as 16-bit words (17-bit accumulator, end-around carry folded each word). At byte 34 the folded sum must be 0xFFFF, else → DISCARD with frame_drop, before any prefix byte is emitted.
- Not defined: no header checksum logic is present; frames are accepted regardless of header checksum.

Test Plan:
- Unicast frame to LOCAL_MAC, dst IP 192.18.8.8, port 0x1918, UDP length 384 (2×188 TS) → one 382-cycle burst: C0 12 08 08 19 18, then 376 payload bytes in order. First output 1 cycle after input byte 36. frame_drop stays 0.
- Same frame with UDP length 196 (1 TS) padded to 300 frame bytes → burst of 194 bytes; padding not forwarded.
- Ethertype 0x0806, and separately protocol 6 → udp_dout_en never rises, one frame_drop pulse each.
- Port 0x0050 (< PORT_MIN) → udp_dout_en high for exactly 1 cycle (IP0), then a single frame_drop pulse.
- Frame cut after byte 100 of a 384-length payload → burst ends 1 cycle after the last input byte, one frame_drop pulse, next back-to-back frame parsed normally.
- rst pulse at byte 60 with mac_din_en held high → no output for the rest of that frame. The following frame is fully forwarded.
- With IPV4_CSUM_CHECK_EN, header checksum corrupted by 1 → no output, one frame_drop pulse; correct checksum → first scenario's output.
